// File: rtl/ise_frame_sched_pkg.sv
// Shared constants and types for the ISE front-end scheduler.
package ise_pkg;

    localparam logic [1:0] COL_R = 2'd0;
    localparam logic [1:0] COL_G = 2'd1;
    localparam logic [1:0] COL_B = 2'd2;

    localparam int unsigned PIXELS_PER_IMG = 16384;
    localparam int unsigned NUM_IMG        = 32;
    localparam int unsigned PIX_W          = 24;

    typedef enum logic [2:0] {
        IDLE,
        STREAM,
        SORT,
        DRAIN,
        DONE
    } sched_state_t;

endpackage

// File: rtl/ise_frame_sched_if.sv
// Pixel-source handshake bundle: sources drive request/valid/pixel, scheduler returns grant/ready.
interface ise_frame_sched_if #(
    parameter int unsigned NUM_SRC = 4
);
    import ise_pkg::*;

    logic [NUM_SRC-1:0]       src_req;
    logic [NUM_SRC-1:0]       src_valid;
    logic [PIX_W*NUM_SRC-1:0] src_pixel;
    logic [NUM_SRC-1:0]       src_ready;
    logic [NUM_SRC-1:0]       src_gnt;

    modport master (
        output src_req,
        output src_valid,
        output src_pixel,
        input  src_ready,
        input  src_gnt
    );

    modport slave (
        input  src_req,
        input  src_valid,
        input  src_pixel,
        output src_ready,
        output src_gnt
    );

endinterface

// File: rtl/ise_frame_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after the pointer wins.
module ise_rr_arbiter #(
    parameter  int unsigned NUM_SRC = 4,
    localparam int unsigned PTR_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [PTR_W-1:0]   pointer,
    output logic [NUM_SRC-1:0] gnt,
    output logic               valid
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            idx = PTR_W'((32'(pointer) + i) % NUM_SRC);
            if (!valid && req[idx]) begin
                gnt[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ise_frame_sched.sv
// ISE front-end scheduler: round-robin image grants, engine clock gating, result tagging.
// Optional stall counter built when ISE_SCHED_STALL_CNT_EN is defined.
module ise_frame_sched
    import ise_pkg::*;
#(
    parameter  int unsigned NUM_SRC        = 4,
    parameter  int unsigned PIXELS_PER_IMG = ise_pkg::PIXELS_PER_IMG,
    parameter  int unsigned NUM_IMG        = ise_pkg::NUM_IMG,
    localparam int unsigned SRC_W          = $clog2(NUM_SRC)
) (
    input  logic                   clk,
    input  logic                   reset,
    ise_frame_sched_if.slave       src,
    output logic                   eng_clk_en,
    output logic [PIX_W-1:0]       eng_pixel_in,
    output logic [4:0]             eng_image_index,
    input  logic                   eng_busy,
    input  logic                   eng_out_valid,
    input  logic [1:0]             eng_color,
    input  logic [4:0]             eng_image_out,
    output logic                   res_valid,
    output logic [SRC_W-1:0]       res_src,
    output logic [1:0]             res_color,
    output logic [4:0]             res_image,
    output logic                   done,
    output logic [15:0]            stall_cnt
);

    sched_state_t     state;
    logic [13:0]      pix_cnt;
    logic [4:0]       img_cnt;
    logic [5:0]       res_cnt;
    logic [SRC_W-1:0] rr_ptr;
    logic [SRC_W-1:0] gnt_idx;
    logic [SRC_W-1:0] owner [NUM_IMG];

    logic [NUM_SRC-1:0] arb_gnt;
    logic               arb_valid;
    logic [SRC_W-1:0]   arb_idx;
    logic [SRC_W-1:0]   rr_next;
    logic               beat_ok;
    logic               last_beat;

    ise_rr_arbiter #(
        .NUM_SRC (NUM_SRC)
    ) u_arb (
        .req     (src.src_req),
        .pointer (rr_ptr),
        .gnt     (arb_gnt),
        .valid   (arb_valid)
    );

    always_comb begin
        arb_idx = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (arb_gnt[i]) arb_idx = SRC_W'(i);
        end
        rr_next = (arb_idx == SRC_W'(NUM_SRC - 1)) ? '0 : arb_idx + 1'b1;
    end

    assign beat_ok   = (state == STREAM) && src.src_valid[gnt_idx];
    assign last_beat = (pix_cnt == 14'(PIXELS_PER_IMG - 1));

    // The engine clock only ticks on valid pixels while streaming, so an
    // underrun simply freezes the engine instead of losing a beat.
    always_comb begin
        src.src_ready = src.src_gnt;
        eng_pixel_in  = '0;
        eng_clk_en    = 1'b0;
        unique case (state)
            STREAM: begin
                eng_pixel_in = src.src_pixel[gnt_idx*PIX_W +: PIX_W];
                eng_clk_en   = src.src_valid[gnt_idx];
            end
            SORT, DRAIN: eng_clk_en = 1'b1;
            default:     eng_clk_en = 1'b0;
        endcase
    end

    assign eng_image_index = img_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pix_cnt     <= '0;
            img_cnt     <= '0;
            res_cnt     <= '0;
            rr_ptr      <= '0;
            gnt_idx     <= '0;
            src.src_gnt <= '0;
            res_valid   <= 1'b0;
            res_src     <= '0;
            res_color   <= '0;
            res_image   <= '0;
            done        <= 1'b0;
            for (int unsigned i = 0; i < NUM_IMG; i++) owner[i] <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (arb_valid) begin
                        src.src_gnt    <= arb_gnt;
                        gnt_idx        <= arb_idx;
                        owner[img_cnt] <= arb_idx;
                        rr_ptr         <= rr_next;
                        state          <= STREAM;
                    end
                end
                STREAM: begin
                    if (beat_ok) begin
                        if (last_beat) begin
                            pix_cnt     <= '0;
                            src.src_gnt <= '0;
                            state       <= SORT;
                        end else begin
                            pix_cnt <= pix_cnt + 1'b1;
                        end
                    end
                end
                SORT: begin
                    // The engine keeps busy high after the final image, so leave without waiting.
                    if (img_cnt == 5'(NUM_IMG - 1)) begin
                        state <= DRAIN;
                    end else if (!eng_busy) begin
                        img_cnt <= img_cnt + 1'b1;
                        state   <= IDLE;
                    end
                end
                DRAIN: begin
                    if (res_cnt == 6'(NUM_IMG)) begin
                        res_valid <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else if (eng_out_valid) begin
                        res_valid <= 1'b1;
                        res_color <= eng_color;
                        res_image <= eng_image_out;
                        res_src   <= owner[eng_image_out];
                        res_cnt   <= res_cnt + 1'b1;
                    end else begin
                        res_valid <= 1'b0;
                    end
                end
                DONE: begin
                    res_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ISE_SCHED_STALL_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (state == STREAM && !src.src_valid[gnt_idx] && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ise_frame_sched.sv
// Randomized self-checking bench for ise_frame_sched with a behavioural engine and scheduling model.
module tb_ise_frame_sched;

    localparam int NS  = 4;
    localparam int PPI = 128;
    localparam int NI  = 32;
`ifdef ISE_SCHED_STALL_CNT_EN
    localparam int EXP_STALL = 7;
`else
    localparam int EXP_STALL = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        eng_clk_en;
    logic [23:0] eng_pixel_in;
    logic [4:0]  eng_image_index;
    logic        eng_busy;
    logic        eng_out_valid;
    logic [1:0]  eng_color;
    logic [4:0]  eng_image_out;
    logic        res_valid;
    logic [1:0]  res_src;
    logic [1:0]  res_color;
    logic [4:0]  res_image;
    logic        done;
    logic [15:0] stall_cnt;

    ise_frame_sched_if #(.NUM_SRC(NS)) sif ();

    ise_frame_sched #(
        .NUM_SRC        (NS),
        .PIXELS_PER_IMG (PPI),
        .NUM_IMG        (NI)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .src             (sif),
        .eng_clk_en      (eng_clk_en),
        .eng_pixel_in    (eng_pixel_in),
        .eng_image_index (eng_image_index),
        .eng_busy        (eng_busy),
        .eng_out_valid   (eng_out_valid),
        .eng_color       (eng_color),
        .eng_image_out   (eng_image_out),
        .res_valid       (res_valid),
        .res_src         (res_src),
        .res_color       (res_color),
        .res_image       (res_image),
        .done            (done),
        .stall_cnt       (stall_cnt)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int exp_rr;
    int exp_img;
    int owner_ref [NI];

    typedef struct packed {
        logic [1:0] c;
        logic [4:0] i;
    } res_t;
    res_t res_q [$];

    // Engine model: loads PPI pixels per image on enabled edges, sorts for a
    // random time, and after the last image emits NI results as a permutation.
    int   e_pix, e_img, e_phase, e_left, e_emit, e_off;
    res_t e_r;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            eng_busy      <= 1'b0;
            eng_out_valid <= 1'b0;
            eng_color     <= '0;
            eng_image_out <= '0;
            e_pix = 0; e_img = 0; e_phase = 0; e_left = 0; e_emit = 0; e_off = 0;
            res_q.delete();
        end else if (eng_clk_en) begin
            case (e_phase)
                0: if (sif.src_gnt != 0) begin
                    e_pix++;
                    if (e_pix == PPI) begin
                        e_pix = 0;
                        eng_busy <= 1'b1;
                        if (e_img == NI - 1) begin
                            e_phase = 2;
                            e_off   = $urandom_range(0, 31);
                            e_emit  = 0;
                        end else begin
                            e_phase = 1;
                            e_left  = $urandom_range(0, 4);
                        end
                        e_img++;
                    end
                end
                1: if (e_left == 0) begin
                    eng_busy <= 1'b0;
                    e_phase = 0;
                end else begin
                    e_left--;
                end
                default: if (e_emit < NI && $urandom_range(0, 1) == 1) begin
                    e_r.c = 2'($urandom_range(0, 2));
                    e_r.i = 5'((e_emit * 7 + e_off) % 32);
                    eng_out_valid <= 1'b1;
                    eng_color     <= e_r.c;
                    eng_image_out <= e_r.i;
                    res_q.push_back(e_r);
                    e_emit++;
                end else begin
                    eng_out_valid <= 1'b0;
                end
            endcase
        end
    end

    function automatic logic [23:0] pix(input int k, input int img, input int beat);
        return {8'(k * 37 + img), 16'(beat * 131 + img * 7)};
    endfunction

    task automatic apply_reset();
        reset = 1'b1;
        sif.src_req   = '0;
        sif.src_valid = '0;
        sif.src_pixel = '0;
        repeat (2) @(negedge clk);
        reset   = 1'b0;
        exp_rr  = 0;
        exp_img = 0;
    endtask

    task automatic do_image(input logic [NS-1:0] req, input int stall_at, input int stall_len,
                            input bit rnd, input int abort_at, output int gated);
        int k, beat, cyc, rem;
        logic v;
        logic [23:0] px;
        logic [NS-1:0] want;
        gated = 0;
        sif.src_req = req;
        k = -1;
        for (int i = 0; i < NS; i++)
            if (k < 0 && req[(exp_rr + i) % NS]) k = (exp_rr + i) % NS;
        want = '0;
        want[k] = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (sif.src_gnt == 0 && cyc < 64);
        n_cmp++;
        if (sif.src_gnt !== want) begin
            n_bad++;
            $display("FAIL grant img%0d: got %b want %b", exp_img, sif.src_gnt, want);
        end
        if (sif.src_gnt == 0) return;
        owner_ref[exp_img] = k;
        exp_rr = (k + 1) % NS;
        beat = 0;
        rem  = stall_len;
        cyc  = 0;
        while (beat < PPI && cyc < 8 * PPI) begin
            if (beat == abort_at) return;
            if (beat == stall_at && rem > 0) begin
                v = 1'b0;
                rem--;
            end else begin
                v = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            if (rnd && $urandom_range(0, 15) == 0) sif.src_req = NS'($urandom);
            sif.src_valid = NS'($urandom);
            sif.src_valid[k] = v;
            for (int s = 0; s < NS; s++) sif.src_pixel[24*s +: 24] = 24'($urandom);
            px = pix(k, exp_img, beat);
            sif.src_pixel[24*k +: 24] = px;
            #1;
            n_cmp++;
            if (sif.src_gnt !== want || sif.src_ready !== want) begin
                n_bad++;
                $display("FAIL gnt/ready img%0d beat%0d: got %b/%b want %b", exp_img, beat,
                         sif.src_gnt, sif.src_ready, want);
            end
            n_cmp++;
            if (eng_clk_en !== v) begin
                n_bad++;
                $display("FAIL clk_en img%0d beat%0d: got %b want %b", exp_img, beat, eng_clk_en, v);
            end
            if (v) begin
                n_cmp++;
                if (eng_pixel_in !== px || eng_image_index !== 5'(exp_img)) begin
                    n_bad++;
                    $display("FAIL pixel img%0d beat%0d: got %h/%0d want %h/%0d", exp_img, beat,
                             eng_pixel_in, eng_image_index, px, exp_img);
                end
            end
            if (eng_clk_en !== 1'b1) gated++;
            if (v) beat++;
            cyc++;
            @(negedge clk);
        end
        n_cmp++;
        if (beat != PPI) begin
            n_bad++;
            $display("FAIL beat_count img%0d: got %0d want %0d", exp_img, beat, PPI);
        end
        sif.src_valid = '0;
        #1;
        n_cmp++;
        if (sif.src_gnt !== '0 || eng_clk_en !== 1'b1) begin
            n_bad++;
            $display("FAIL end_of_image img%0d: gnt %b clk_en %b want 0000/1", exp_img,
                     sif.src_gnt, eng_clk_en);
        end
        exp_img++;
    endtask

    task automatic check_drain();
        int cyc, n_res;
        res_t r;
        cyc = 0;
        n_res = 0;
        while (done !== 1'b1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (res_valid === 1'b1) begin
                n_cmp++;
                if (res_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL result_extra: got image %0d want none", res_image);
                end else begin
                    r = res_q.pop_front();
                    if (res_image !== r.i || res_color !== r.c ||
                        res_src !== 2'(owner_ref[r.i])) begin
                        n_bad++;
                        $display("FAIL result: got img%0d col%0d src%0d want img%0d col%0d src%0d",
                                 res_image, res_color, res_src, r.i, r.c, owner_ref[r.i]);
                    end
                end
                n_res++;
            end
        end
        n_cmp++;
        if (done !== 1'b1 || n_res != NI || res_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL drain: got done %b results %0d res_valid %b want 1/%0d/0",
                     done, n_res, res_valid, NI);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        repeat (2) begin
            @(negedge clk);
            n_cmp++;
            if ({sif.src_gnt, sif.src_ready, eng_clk_en, eng_pixel_in, eng_image_index, res_valid,
                 res_src, res_color, res_image, done, stall_cnt} !== '0) begin
                n_bad++;
                $display("FAIL reset_outputs: got gnt %b clk_en %b res_valid %b done %b stall %0d want all 0",
                         sif.src_gnt, eng_clk_en, res_valid, done, stall_cnt);
            end
        end
    endtask

    task automatic test_single_source();
        int g;
        apply_reset();
        do_image(4'b0100, -1, 0, 1'b0, -1, g);
        n_cmp++;
        if (g != 0 || stall_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL single_source: got gated %0d stall %0d want 0/0", g, stall_cnt);
        end
    endtask

    task automatic test_alternate();
        int g;
        apply_reset();
        for (int i = 0; i < NI; i++) do_image(4'b1001, -1, 0, 1'b1, -1, g);
        check_drain();
    endtask

    task automatic test_underrun();
        int g;
        apply_reset();
        do_image(4'b0010, 100, 7, 1'b0, -1, g);
        n_cmp++;
        if (g != 7) begin
            n_bad++;
            $display("FAIL underrun_gated: got %0d want 7", g);
        end
        n_cmp++;
        if (stall_cnt !== 16'(EXP_STALL)) begin
            n_bad++;
            $display("FAIL stall_cnt: got %0d want %0d", stall_cnt, EXP_STALL);
        end
    endtask

    task automatic test_full_batch();
        int g;
        logic [NS-1:0] req;
        apply_reset();
        for (int i = 0; i < NI; i++) begin
            do req = NS'($urandom); while (req == 0);
            do_image(req, -1, 0, 1'b1, -1, g);
        end
        check_drain();
    endtask

    task automatic test_after_done();
        sif.src_req = '1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            sif.src_valid = NS'($urandom);
            #1;
            n_cmp++;
            if (sif.src_gnt !== '0 || sif.src_ready !== '0 || eng_clk_en !== 1'b0 || done !== 1'b1) begin
                n_bad++;
                $display("FAIL after_done: got gnt %b ready %b clk_en %b done %b want 0/0/0/1",
                         sif.src_gnt, sif.src_ready, eng_clk_en, done);
            end
        end
    endtask

    task automatic test_reset_mid();
        int g;
        apply_reset();
        for (int i = 0; i < 3; i++) do_image(4'b1111, -1, 0, 1'b1, -1, g);
        do_image(4'b1111, -1, 0, 1'b1, 50, g);
        reset = 1'b1;
        sif.src_valid = '0;
        #1;
        n_cmp++;
        if ({sif.src_gnt, sif.src_ready, eng_clk_en, eng_pixel_in, eng_image_index, res_valid,
             res_src, res_color, res_image, done, stall_cnt} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid: got gnt %b clk_en %b idx %0d stall %0d want all 0",
                     sif.src_gnt, eng_clk_en, eng_image_index, stall_cnt);
        end
        @(negedge clk);
        reset   = 1'b0;
        exp_rr  = 0;
        exp_img = 0;
        do_image(4'b1111, -1, 0, 1'b1, -1, g);
    endtask

    initial begin
        test_reset();
        test_single_source();
        test_alternate();
        test_underrun();
        test_reset_mid();
        test_full_batch();
        test_after_done();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
